mem_stage: RTL
==============

# mem_stage

Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. It owns the EX/MEM pipeline register, the word-organised data RAM with byte/halfword/word access, and the MEM/WB pipeline register. It also produces the forwarding sources (`*_from_exmereg`, `*_from_memwbreg`, `BusW_from_wb`) that the execute stage's bypass muxes select between.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024 — data RAM depth in 32-bit words; power of two.
- `ADDR_W`, log2(`DEPTH_WORDS`) — word-index width; derived, not overridden.

Ports:
- `Clk`  in  1  — single clock, rising edge.
- `Rst_n`  in  1  — reset, asynchronous, active-low.
- `Stall`  in  1  — hold EX/MEM contents.
- `Flush`  in  1  — load a bubble into EX/MEM.
- `Result`  in  32  — execute-stage ALU result: address for memory ops, otherwise the writeback value.
- `BusB_exe`  in  32  — forwarded store data.
- `Rw`  in  5  — destination register.
- `RegWr`, `MemWr`, `MemRead`, `MemToReg`, `MemSigned`, `HiLoWr`  in  1 each — control signals.
- `MemSize`  in  2  — access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `LoRe`, `HiRe`  in  32 each — execute-stage Lo/Hi results.
- `Result_from_exmereg`, `LoRe_from_exmereg`, `HiRe_from_exmereg`  out  32 — EX/MEM contents.
- `Rw_mem`  out  5, `RegWr_mem`  out  1 — EX/MEM destination register and write enable, for hazard detection.
- `BusW_from_wb`  out  32 — selected writeback value.
- `Rw_wb`  out  5, `RegWr_wb`  out  1 — MEM/WB destination register and write enable.
- `LoRe_from_memwbreg`, `HiRe_from_memwbreg`  out  32, `HiLoWr_wb`  out  1 — MEM/WB Lo/Hi contents.
- `AddrErr`  out  1 — registered misaligned-access fault, held in MEM/WB.

## Operation
**EX/MEM register**
- Priority per edge: `Flush` (capture a bubble: every control bit 0, data 0), then `Stall` (hold), else capture the inputs.

**Address and alignment**
- Word index is `Result[ADDR_W+1:2]`; the upper address bits are ignored, so the address wraps modulo RAM size.
- Misalignment: a halfword access with `Result[0]`=1, or a word access with `Result[1:0]`≠0.
- A misaligned access performs no RAM write, forces `RegWr` low into MEM/WB, and sets `AddrErr`.

**RAM**
- Reads are combinational from the EX/MEM address.
- Writes are synchronous at the end of the MEM cycle.
- Write enable = `MemWr_m & ~misaligned & ~Stall`.
- Little-endian byte lanes:
  - byte store writes lane `addr[1:0]` with `data[7:0]`;
  - half store writes lanes {1,0} or {3,2} with `data[15:0]`;
  - other lanes are preserved.

**Load extract**
- Select the addressed lane or halfword, then zero- or sign-extend per `MemSigned`.
- Word loads pass through unchanged.

**MEM/WB register**
- Captures every cycle.
- While `Stall`=1, it captures a bubble (`RegWr_wb`=0, `HiLoWr_wb`=0, `AddrErr`=0). This makes the held instruction retire exactly once.
- `BusW_from_wb` = `MemToReg` ? load data : EX/MEM `Result`.

**Reset**
- Every output and both pipeline registers go to 0.
- RAM contents are not reset.

## Timing
- Latency: inputs captured at edge N → visible on `*_from_exmereg` after N → RAM write and `*_wb` outputs after edge N+1.
- The load result is available in `BusW_from_wb` one cycle after EX/MEM. Load-use spacing of 1 requires a stall, which is upstream hazard logic.
- Read-after-write to the same address in consecutive instructions: the second instruction's combinational read sees the value written at the preceding edge.
- `Flush` and `Stall` asserted together: the flush wins, and MEM/WB still gets a bubble.
- `Rst_n` falling mid-store: the write is abandoned and outputs clear immediately. On release, the first edge captures normally.

## Structure
- Shared package `pipe_pkg`: `MemSize` encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`) and the bubble constant for control bundles.
- One natural sub-module, `data_ram`: byte-lane-enabled synchronous-write, asynchronous-read RAM parameterised by `DEPTH_WORDS`.
- Lane select, extension and alignment checks stay in `mem_stage`.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word from 0x10 → `BusW_from_wb`=0xDEADBEEF, `RegWr_wb`=1.
- Store byte 0x80 at 0x13 over 0x11223344, then load byte signed from 0x13 → 0xFFFFFF80; load word from 0x10 → 0x80223344.
- Load half from 0x12 with `MemSigned`=0 over 0x8765_4321 → 0x00008765.
- Word load from 0x21 → `AddrErr`=1, `RegWr_wb`=0. Word store to 0x22 → RAM unchanged.
- Store with `Stall` held for 3 cycles → exactly one write; `RegWr_wb` low during the stall. `Flush` together with `Stall` → EX/MEM is a bubble.
- Assert `Rst_n`=0 mid-pipeline → all outputs 0 asynchronously. After release, ALU result 0x55 with `RegWr`=1 → `BusW_from_wb`=0x55 two edges later.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: access-size encodings and the control-bundle bubble shared by pipeline stages.
// rev 1.0
package pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic       regwr;
    logic       memwr;
    logic       memread;
    logic       memtoreg;
    logic       memsigned;
    logic       hilowr;
    logic [1:0] memsize;
  } mem_ctrl_t;

  localparam mem_ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// data_ram: word-organised RAM, byte-lane write enables, synchronous write / asynchronous read.
// rev 1.0
module data_ram #(
  parameter int  DEPTH_WORDS = 1024,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (be[lane]) mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// mem_stage: EX/MEM register, data RAM access with alignment checks, MEM/WB register.
// rev 1.0
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] Result,
  input  logic [31:0] BusB_exe,
  input  logic [4:0]  Rw,
  input  logic        RegWr,
  input  logic        MemWr,
  input  logic        MemRead,
  input  logic        MemToReg,
  input  logic        MemSigned,
  input  logic        HiLoWr,
  input  logic [1:0]  MemSize,
  input  logic [31:0] LoRe,
  input  logic [31:0] HiRe,
  output logic [31:0] Result_from_exmereg,
  output logic [31:0] LoRe_from_exmereg,
  output logic [31:0] HiRe_from_exmereg,
  output logic [4:0]  Rw_mem,
  output logic        RegWr_mem,
  output logic [31:0] BusW_from_wb,
  output logic [4:0]  Rw_wb,
  output logic        RegWr_wb,
  output logic [31:0] LoRe_from_memwbreg,
  output logic [31:0] HiRe_from_memwbreg,
  output logic        HiLoWr_wb,
  output logic        AddrErr
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  mem_ctrl_t   ctrl_in, ctrl_m;
  logic [31:0] result_m, busb_m, lo_m, hi_m;
  logic [4:0]  rw_m;

  assign ctrl_in = {RegWr, MemWr, MemRead, MemToReg, MemSigned, HiLoWr, MemSize};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ctrl_m   <= CTRL_BUBBLE;
      result_m <= '0;
      busb_m   <= '0;
      lo_m     <= '0;
      hi_m     <= '0;
      rw_m     <= '0;
    end else if (Flush) begin
      ctrl_m   <= CTRL_BUBBLE;
      result_m <= '0;
      busb_m   <= '0;
      lo_m     <= '0;
      hi_m     <= '0;
      rw_m     <= '0;
    end else if (!Stall) begin
      ctrl_m   <= ctrl_in;
      result_m <= Result;
      busb_m   <= BusB_exe;
      lo_m     <= LoRe;
      hi_m     <= HiRe;
      rw_m     <= Rw;
    end
  end

  assign Result_from_exmereg = result_m;
  assign LoRe_from_exmereg   = lo_m;
  assign HiRe_from_exmereg   = hi_m;
  assign Rw_mem              = rw_m;
  assign RegWr_mem           = ctrl_m.regwr;

  logic        misaligned, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata, load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Only real memory operations can fault; ALU results with odd low bits are fine.
  always_comb begin
    misaligned = 1'b0;
    if (ctrl_m.memwr || ctrl_m.memread) begin
      case (ctrl_m.memsize)
        SZ_BYTE: misaligned = 1'b0;
        SZ_HALF: misaligned = result_m[0];
        default: misaligned = |result_m[1:0];
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (ctrl_m.memsize)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << result_m[1:0];
        ram_wdata = {4{busb_m[7:0]}};
      end
      SZ_HALF: begin
        ram_be    = result_m[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{busb_m[15:0]}};
      end
      default: begin
        ram_be    = 4'b1111;
        ram_wdata = busb_m;
      end
    endcase
  end

  assign ram_we = ctrl_m.memwr & ~misaligned & ~Stall;

  data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_data_ram (
    .clk   (Clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (result_m[ADDR_W+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign load_byte = ram_rdata[{result_m[1:0], 3'b000} +: 8];
  assign load_half = ram_rdata[{result_m[1], 4'b0000} +: 16];

  always_comb begin
    case (ctrl_m.memsize)
      SZ_BYTE: load_data = {{24{ctrl_m.memsigned & load_byte[7]}}, load_byte};
      SZ_HALF: load_data = {{16{ctrl_m.memsigned & load_half[15]}}, load_half};
      default: load_data = ram_rdata;
    endcase
  end

  // A stalled instruction stays in EX/MEM, so MEM/WB takes a bubble to retire it only once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      BusW_from_wb       <= '0;
      Rw_wb              <= '0;
      RegWr_wb           <= 1'b0;
      LoRe_from_memwbreg <= '0;
      HiRe_from_memwbreg <= '0;
      HiLoWr_wb          <= 1'b0;
      AddrErr            <= 1'b0;
    end else begin
      BusW_from_wb       <= ctrl_m.memtoreg ? load_data : result_m;
      Rw_wb              <= rw_m;
      LoRe_from_memwbreg <= lo_m;
      HiRe_from_memwbreg <= hi_m;
      if (Stall) begin
        RegWr_wb  <= 1'b0;
        HiLoWr_wb <= 1'b0;
        AddrErr   <= 1'b0;
      end else begin
        RegWr_wb  <= ctrl_m.regwr & ~misaligned;
        HiLoWr_wb <= ctrl_m.hilowr;
        AddrErr   <= misaligned;
      end
    end
  end

endmodule
`default_nettype wire
